ensemble_voter: RTL

- Sits directly downstream of the three-classifier ensemble wrapper.
- Consumes the three per-classifier AXI-Stream prediction streams: slot 0 = gaussian_nb, slot 1 = gradient_boost, slot 2 = mlp.
- Aligns them sample-by-sample with per-input FIFOs, majority-votes the class label and emits one AXI-Stream result per sample with an agreement count.
- Absorbs the differing per-classifier latencies so the upstream cores never stall one another.

---
 rtl/ensemble_voter_pkg.sv | 28 ++
 rtl/ensemble_voter_if.sv | 39 +++
 rtl/ensemble_voter_vote_fifo.sv | 64 ++++++
 rtl/ensemble_voter.sv | 159 +++++++++++++++
 4 files changed

// File: rtl/ensemble_voter_pkg.sv
// Shared constants and types for the ensemble voter.
// Slot numbering follows the upstream ensemble wrapper's classifier order.
package ensemble_pkg;

   localparam int CLASS_W_DEFAULT = 8;

   localparam int NUM_SLOTS = 3;
   localparam int SLOT_GNB  = 0;
   localparam int SLOT_GB   = 1;
   localparam int SLOT_MLP  = 2;

   typedef enum logic [1:0] {
      AGREE_NONE = 2'd1,
      AGREE_TWO  = 2'd2,
      AGREE_ALL  = 2'd3
   } agree_t;

   // Agreement level from the three pairwise label comparisons.
   function automatic agree_t agree_count(input logic eq01, input logic eq02, input logic eq12);
      if (eq01 && eq02)
         return AGREE_ALL;
      else if (eq01 || eq02 || eq12)
         return AGREE_TWO;
      else
         return AGREE_NONE;
   endfunction

endpackage

// File: rtl/ensemble_voter_if.sv
// AXI-Stream bundle for the ensemble voter: three prediction inputs and one
// voted result output. The voter uses the slave view; the environment
// (upstream classifiers plus downstream sink) uses the master view.
interface ensemble_voter_if #(
   parameter int DATA_WIDTH = 32,
   parameter int KEEP_WIDTH = 4
);
   logic [DATA_WIDTH-1:0] s_axis_tdata_0, s_axis_tdata_1, s_axis_tdata_2;
   logic [KEEP_WIDTH-1:0] s_axis_tkeep_0, s_axis_tkeep_1, s_axis_tkeep_2;
   logic                  s_axis_tvalid_0, s_axis_tvalid_1, s_axis_tvalid_2;
   logic                  s_axis_tready_0, s_axis_tready_1, s_axis_tready_2;
   logic                  s_axis_tlast_0, s_axis_tlast_1, s_axis_tlast_2;

   logic [DATA_WIDTH-1:0] m_axis_tdata;
   logic [KEEP_WIDTH-1:0] m_axis_tkeep;
   logic                  m_axis_tvalid;
   logic                  m_axis_tready;
   logic                  m_axis_tlast;

   modport slave (
      input  s_axis_tdata_0, s_axis_tdata_1, s_axis_tdata_2,
      input  s_axis_tkeep_0, s_axis_tkeep_1, s_axis_tkeep_2,
      input  s_axis_tvalid_0, s_axis_tvalid_1, s_axis_tvalid_2,
      output s_axis_tready_0, s_axis_tready_1, s_axis_tready_2,
      input  s_axis_tlast_0, s_axis_tlast_1, s_axis_tlast_2,
      output m_axis_tdata, m_axis_tkeep, m_axis_tvalid, m_axis_tlast,
      input  m_axis_tready
   );

   modport master (
      output s_axis_tdata_0, s_axis_tdata_1, s_axis_tdata_2,
      output s_axis_tkeep_0, s_axis_tkeep_1, s_axis_tkeep_2,
      output s_axis_tvalid_0, s_axis_tvalid_1, s_axis_tvalid_2,
      input  s_axis_tready_0, s_axis_tready_1, s_axis_tready_2,
      output s_axis_tlast_0, s_axis_tlast_1, s_axis_tlast_2,
      input  m_axis_tdata, m_axis_tkeep, m_axis_tvalid, m_axis_tlast,
      output m_axis_tready
   );
endinterface

// File: rtl/ensemble_voter_vote_fifo.sv
// Per-slot alignment FIFO. Ready and empty are registered (decoded from the
// next-state pointers) so there is no combinational path from pop to ready:
// a pop while full re-opens ready on the following cycle.
// Pointers carry one extra wrap bit; full/empty come from the MSB difference.
module vote_fifo #(
   parameter int WIDTH = 9,
   parameter int DEPTH = 8
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             push_i,
   input  logic [WIDTH-1:0] wdata_i,
   input  logic             pop_i,
   output logic [WIDTH-1:0] rdata_o,
   output logic             ready_o,
   output logic             empty_o
);
   localparam int AW = $clog2(DEPTH);

   logic [AW:0]      wr_ptr_q, wr_ptr_d;
   logic [AW:0]      rd_ptr_q, rd_ptr_d;
   logic             full_q, full_d;
   logic             empty_q, empty_d;
   logic             do_push, do_pop;
   logic [WIDTH-1:0] mem_q [DEPTH];

   assign do_push = push_i && !full_q;
   assign do_pop  = pop_i && !empty_q;

   // Next pointers and the flags they imply.
   always_comb begin
      wr_ptr_d = wr_ptr_q + (AW+1)'(do_push);
      rd_ptr_d = rd_ptr_q + (AW+1)'(do_pop);
      empty_d  = (wr_ptr_d == rd_ptr_d);
      full_d   = (wr_ptr_d[AW] != rd_ptr_d[AW]) &&
                 (wr_ptr_d[AW-1:0] == rd_ptr_d[AW-1:0]);
   end

   // Pointer and flag registers.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         wr_ptr_q <= '0;
         rd_ptr_q <= '0;
         full_q   <= 1'b0;
         empty_q  <= 1'b1;
      end else begin
         wr_ptr_q <= wr_ptr_d;
         rd_ptr_q <= rd_ptr_d;
         full_q   <= full_d;
         empty_q  <= empty_d;
      end
   end

   // Storage; contents are don't-care until written, so no reset.
   always_ff @(posedge clk) begin
      if (do_push)
         mem_q[wr_ptr_q[AW-1:0]] <= wdata_i;
   end

   assign rdata_o = mem_q[rd_ptr_q[AW-1:0]];
   assign ready_o = !full_q;
   assign empty_o = empty_q;

endmodule

// File: rtl/ensemble_voter.sv
// Ensemble voter: aligns the three classifier prediction streams through
// per-slot FIFOs, majority-votes the class label and emits one result per
// sample as {agreement count, label}. Slot 0 supplies the output tlast.
// Optional build macro VOTER_STATS_EN adds saturating sample/unanimous/tie
// counters as extra output ports.
module ensemble_voter
   import ensemble_pkg::*;
#(
   parameter int DATA_WIDTH = 32,
   parameter int KEEP_WIDTH = 4,
   parameter int CLASS_W    = CLASS_W_DEFAULT,
   parameter int FIFO_DEPTH = 8,
   parameter int TIE_SRC    = SLOT_MLP
) (
   input  logic             clk,
   input  logic             rst_n,
   ensemble_voter_if.slave  bus,
   output logic             err_tlast_mismatch
`ifdef VOTER_STATS_EN
   ,
   output logic [31:0]      stat_samples,
   output logic [31:0]      stat_unanimous,
   output logic [31:0]      stat_tie
`endif
);
   localparam int EW = CLASS_W + 1;

   logic [EW-1:0]      wdata [NUM_SLOTS];
   logic [EW-1:0]      head  [NUM_SLOTS];
   logic [NUM_SLOTS-1:0] push, ready, empty;
   logic [CLASS_W-1:0] lbl   [NUM_SLOTS];
   logic [NUM_SLOTS-1:0] lst;

   logic               fire;
   logic               eq01, eq02, eq12;
   logic [CLASS_W-1:0] vote_lbl;
   agree_t             vote_cnt;
   logic               lst_mismatch;

   logic [DATA_WIDTH-1:0] tdata_q, tdata_d;
   logic [KEEP_WIDTH-1:0] tkeep_q;
   logic                  tvalid_q;
   logic                  tlast_q;
   logic                  err_q;

   // Upper data bits and tkeep of the inputs carry nothing the vote uses.
   logic unused_inputs;
   assign unused_inputs = ^{bus.s_axis_tkeep_0, bus.s_axis_tkeep_1, bus.s_axis_tkeep_2,
                            bus.s_axis_tdata_0[DATA_WIDTH-1:CLASS_W],
                            bus.s_axis_tdata_1[DATA_WIDTH-1:CLASS_W],
                            bus.s_axis_tdata_2[DATA_WIDTH-1:CLASS_W]};

   assign wdata[SLOT_GNB] = {bus.s_axis_tlast_0, bus.s_axis_tdata_0[CLASS_W-1:0]};
   assign wdata[SLOT_GB]  = {bus.s_axis_tlast_1, bus.s_axis_tdata_1[CLASS_W-1:0]};
   assign wdata[SLOT_MLP] = {bus.s_axis_tlast_2, bus.s_axis_tdata_2[CLASS_W-1:0]};

   assign push[SLOT_GNB] = bus.s_axis_tvalid_0 && ready[SLOT_GNB];
   assign push[SLOT_GB]  = bus.s_axis_tvalid_1 && ready[SLOT_GB];
   assign push[SLOT_MLP] = bus.s_axis_tvalid_2 && ready[SLOT_MLP];

   assign bus.s_axis_tready_0 = ready[SLOT_GNB];
   assign bus.s_axis_tready_1 = ready[SLOT_GB];
   assign bus.s_axis_tready_2 = ready[SLOT_MLP];

   for (genvar g = 0; g < NUM_SLOTS; g++) begin : g_fifo
      vote_fifo #(
         .WIDTH (EW),
         .DEPTH (FIFO_DEPTH)
      ) u_fifo (
         .clk     (clk),
         .rst_n   (rst_n),
         .push_i  (push[g]),
         .wdata_i (wdata[g]),
         .pop_i   (fire),
         .rdata_o (head[g]),
         .ready_o (ready[g]),
         .empty_o (empty[g])
      );
      assign lbl[g] = head[g][CLASS_W-1:0];
      assign lst[g] = head[g][CLASS_W];
   end

   // All three heads present and the output register free (or draining).
   assign fire = !(|empty) && (!tvalid_q || bus.m_axis_tready);

   // Majority vote; when every label differs the configured tie slot wins.
   always_comb begin
      eq01     = (lbl[SLOT_GNB] == lbl[SLOT_GB]);
      eq02     = (lbl[SLOT_GNB] == lbl[SLOT_MLP]);
      eq12     = (lbl[SLOT_GB]  == lbl[SLOT_MLP]);
      vote_cnt = agree_count(eq01, eq02, eq12);
      vote_lbl = lbl[TIE_SRC];
      if (eq01 || eq02)
         vote_lbl = lbl[SLOT_GNB];
      else if (eq12)
         vote_lbl = lbl[SLOT_GB];
      lst_mismatch = (lst[SLOT_GNB] != lst[SLOT_GB]) || (lst[SLOT_GNB] != lst[SLOT_MLP]);
      tdata_d = '0;
      tdata_d[CLASS_W-1:0]       = vote_lbl;
      tdata_d[CLASS_W+1:CLASS_W] = vote_cnt;
   end

   // Output register: loads on fire, holds while stalled, drops after handshake.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         tvalid_q <= 1'b0;
         tdata_q  <= '0;
         tkeep_q  <= '0;
         tlast_q  <= 1'b0;
      end else if (fire) begin
         tvalid_q <= 1'b1;
         tdata_q  <= tdata_d;
         tkeep_q  <= '1;
         tlast_q  <= lst[SLOT_GNB];
      end else if (bus.m_axis_tready) begin
         tvalid_q <= 1'b0;
         tkeep_q  <= '0;
      end
   end

   // Sticky flag for slots disagreeing on batch boundaries.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n)
         err_q <= 1'b0;
      else if (fire && lst_mismatch)
         err_q <= 1'b1;
   end

   assign bus.m_axis_tdata  = tdata_q;
   assign bus.m_axis_tkeep  = tkeep_q;
   assign bus.m_axis_tvalid = tvalid_q;
   assign bus.m_axis_tlast  = tlast_q;
   assign err_tlast_mismatch = err_q;

`ifdef VOTER_STATS_EN
   logic [31:0] samples_q, unanimous_q, tie_q;

   // Saturating statistics, one step per fire.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         samples_q   <= '0;
         unanimous_q <= '0;
         tie_q       <= '0;
      end else if (fire) begin
         if (samples_q != '1)
            samples_q <= samples_q + 32'd1;
         if (vote_cnt == AGREE_ALL && unanimous_q != '1)
            unanimous_q <= unanimous_q + 32'd1;
         if (vote_cnt == AGREE_NONE && tie_q != '1)
            tie_q <= tie_q + 32'd1;
      end
   end

   assign stat_samples   = samples_q;
   assign stat_unanimous = unanimous_q;
   assign stat_tie       = tie_q;
`endif

endmodule
